// File: rtl/deco_rr_arbiter.sv
// rtl/deco_rr_arbiter.sv - round-robin arbiter sharing one 2-to-4 decoder among 4 requesters
// Optional forced release after HOLD_MAX grant cycles: define ARB_TIMEOUT_EN.
module deco_rr_arbiter #(
   parameter int HOLD_MAX = 15,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] done,
   output logic [1:0] sel,
   output logic       en,
   output logic [3:0] gnt,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t     state, state_nx;
   logic [1:0] last, last_nx;
   logic [1:0] sel_nx;
   logic       en_nx;
   logic [3:0] gnt_nx;
   logic       busy_nx;
   logic       found;
   logic [1:0] winner;
   logic [1:0] idx;
   logic       release_req;
   logic       force_rel;

   // Pointer scan: (last+1) upward with wrap, so the previous owner comes last.
   always_comb begin
      found  = 1'b0;
      winner = last;
      idx    = last;
      for (int i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign release_req = done[sel] | ~req[sel];

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             timeout_q, timeout_nx;

   assign force_rel = (cnt == CNT_W'(HOLD_MAX - 1));
   assign timeout   = timeout_q;

   always_comb begin
      cnt_nx     = cnt;
      timeout_nx = 1'b0;
      if (state != GRANT && state_nx == GRANT) begin
         cnt_nx = '0;
      end else if (state == GRANT && state_nx == GRANT) begin
         cnt_nx = (cnt != {CNT_W{1'b1}}) ? cnt + 1'b1 : cnt;
      end
      if (state == GRANT && !release_req && force_rel) begin
         timeout_nx = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt       <= cnt_nx;
         timeout_q <= timeout_nx;
      end
   end
`else
   logic unused_cfg;

   assign force_rel  = 1'b0;
   assign timeout    = 1'b0;
   assign unused_cfg = (HOLD_MAX > 0) ^ (CNT_W > 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         last  <= 2'd3;
         sel   <= 2'd0;
         en    <= 1'b0;
         gnt   <= 4'b0000;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         last  <= last_nx;
         sel   <= sel_nx;
         en    <= en_nx;
         gnt   <= gnt_nx;
         busy  <= busy_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, GAP: state_nx = found ? GRANT : IDLE;
         GRANT:     state_nx = (release_req || force_rel) ? GAP : GRANT;
         default:   state_nx = IDLE;
      endcase
   end

   // Registered outputs are loaded with their next-cycle values.
   always_comb begin
      sel_nx  = sel;
      last_nx = last;
      en_nx   = 1'b0;
      gnt_nx  = 4'b0000;
      busy_nx = (state_nx != IDLE);
      if (state_nx == GRANT) begin
         en_nx = 1'b1;
         if (state != GRANT) begin
            sel_nx  = winner;
            last_nx = winner;
            gnt_nx  = 4'b0001 << winner;
         end else begin
            gnt_nx  = gnt;
         end
      end
   end

endmodule

// File: tb/tb_deco_rr_arbiter.sv
// tb/tb_deco_rr_arbiter.sv - randomized and directed bench for deco_rr_arbiter
module tb_deco_rr_arbiter;

   localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] done;
   logic [1:0] sel;
   logic       en;
   logic [3:0] gnt;
   logic       busy;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   // Reference model: 0 idle, 1 owner holds the decoder, 2 dead cycle.
   int m_state, m_sel, m_last, m_cnt;
   bit m_to;

   always #5 clk = ~clk;

   deco_rr_arbiter #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .sel(sel), .en(en), .gnt(gnt), .busy(busy), .timeout(timeout)
   );

   function automatic int pick(logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (m_last + k) % 4;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_state = 0; m_sel = 0; m_last = 3; m_cnt = 0; m_to = 0;
   endtask

   task automatic model_edge(logic [3:0] r, logic [3:0] d);
      int w;
      m_to = 0;
      if (m_state == 1) begin
         if (d[m_sel] || !r[m_sel]) m_state = 2;
         else if (TO_EN && m_cnt == HOLD - 1) begin
            m_state = 2;
            m_to    = 1;
         end else m_cnt++;
      end else begin
         w = pick(r);
         if (w >= 0) begin
            m_state = 1; m_sel = w; m_last = w; m_cnt = 0;
         end else m_state = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(req, done);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = 4'b0; done = 4'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({sel, en, gnt, busy, timeout} !== 9'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want %b", {sel, en, gnt, busy, timeout}, 9'b0);
      end
   endtask

   task automatic test_single();
      req = 4'b0001;
      step();
      total++;
      if ({sel, en, gnt, busy} !== {2'd0, 1'b1, 4'b0001, 1'b1}) begin
         bad++;
         $display("FAIL single_grant: got %b want %b", {sel, en, gnt, busy}, {2'd0, 1'b1, 4'b0001, 1'b1});
      end
      done = 4'b0001;
      step();
      done = 4'b0000;
      total++;
      if ({en, gnt, busy} !== {1'b0, 4'b0000, 1'b1}) begin
         bad++;
         $display("FAIL single_gap: got %b want %b", {en, gnt, busy}, {1'b0, 4'b0000, 1'b1});
      end
      step();
      total++;
      if (gnt !== 4'b0001 || en !== 1'b1) begin
         bad++;
         $display("FAIL single_regrant: got gnt=%b en=%b want gnt=0001 en=1", gnt, en);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] want;
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         want = 4'b0001 << (k % 4);
         for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (gnt !== want || en !== 1'b1) begin
               bad++;
               $display("FAIL rotation_owner%0d_c%0d: got gnt=%b en=%b want gnt=%b en=1", k, c, gnt, en, want);
            end
         end
         done = want;
         step();
         done = 4'b0000;
         total++;
         if (en !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rotation_gap%0d: got en=%b gnt=%b busy=%b want en=0 gnt=0000 busy=1", k, en, gnt, busy);
         end
      end
   endtask

   task automatic test_non_owner();
      do_reset();
      req = 4'b0100;
      step();
      req  = 4'b0110;
      done = 4'b0010;
      step();
      done = 4'b0000;
      total++;
      if (gnt !== 4'b0100) begin
         bad++;
         $display("FAIL non_owner_ignored: got %b want 0100", gnt);
      end
      req = 4'b0010;
      step();
      total++;
      if (en !== 1'b0 || gnt !== 4'b0000) begin
         bad++;
         $display("FAIL non_owner_gap: got en=%b gnt=%b want en=0 gnt=0000", en, gnt);
      end
      step();
      total++;
      if (gnt !== 4'b0010 || sel !== 2'd1) begin
         bad++;
         $display("FAIL non_owner_next: got gnt=%b sel=%0d want gnt=0010 sel=1", gnt, sel);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0001;
      step();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if ({en, gnt, busy} !== 6'b0) begin
         bad++;
         $display("FAIL async_reset: got en=%b gnt=%b busy=%b want all 0", en, gnt, busy);
      end
      rst_n = 1'b1;
      req   = 4'b1000;
      step();
      total++;
      if (gnt !== 4'b1000 || sel !== 2'd3 || en !== 1'b1) begin
         bad++;
         $display("FAIL after_reset_grant: got gnt=%b sel=%0d en=%b want gnt=1000 sel=3 en=1", gnt, sel, en);
      end
   endtask

   task automatic test_hold();
`ifdef ARB_TIMEOUT_EN
      logic [3:0] exp_g [11];
      logic       exp_t [11];
      exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
      exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      req = 4'b0011;
      for (int c = 0; c < 11; c++) begin
         step();
         total++;
         if (gnt !== exp_g[c] || timeout !== exp_t[c]) begin
            bad++;
            $display("FAIL timeout_seq_c%0d: got gnt=%b timeout=%b want gnt=%b timeout=%b", c, gnt, timeout, exp_g[c], exp_t[c]);
         end
      end
`else
      do_reset();
      req = 4'b0011;
      for (int c = 0; c < 1000; c++) begin
         step();
         total++;
         if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL hold_c%0d: got gnt=%b timeout=%b want gnt=0001 timeout=0", c, gnt, timeout);
         end
      end
`endif
      req = 4'b0000;
   endtask

   task automatic test_random();
      logic [8:0] exp_o;
      logic [3:0] prev_gnt;
      do_reset();
      prev_gnt = 4'b0000;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         done = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
         step();
         exp_o = {2'(m_sel), (m_state == 1), (m_state == 1) ? 4'(1 << m_sel) : 4'b0000,
                  (m_state != 0), m_to};
         total++;
         if ({sel, en, gnt, busy, timeout} !== exp_o) begin
            bad++;
            $display("FAIL random_c%0d: got sel,en,gnt,busy,to=%b want %b", c, {sel, en, gnt, busy, timeout}, exp_o);
         end
         total++;
         if (prev_gnt != 4'b0000 && gnt != 4'b0000 && gnt !== prev_gnt) begin
            bad++;
            $display("FAIL random_handover_c%0d: got gnt %b after %b want a dead cycle", c, gnt, prev_gnt);
         end
         prev_gnt = gnt;
      end
      done = 4'b0000;
   endtask

   initial begin
      rst_n = 1'b0; req = 4'b0; done = 4'b0;
      test_reset();
      test_single();
      test_rotation();
      test_non_owner();
      test_async_reset();
      test_hold();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
